// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt priority controller: FSM encoding,
// bus widths, default vector base and the board-level line assignments.
package irq_pkg;

  localparam int IRQ_VEC_W = 8;
  localparam int IPL_W     = 3;

  localparam logic [IRQ_VEC_W-1:0] VEC_BASE_DEFAULT = 8'h40;

  // Peripheral line indices into irq_in.
  localparam int IRQ_UART    = 0;
  localparam int IRQ_SYSTICK = 1;
  localparam int IRQ_ETH     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } irq_state_e;

endpackage : irq_pkg

// File: rtl/irq_prio_ctrl_if.sv
// Vector handshake between the interrupt controller (master) and the CPU
// bus interface (slave) that consumes it during interrupt acknowledge.
interface irq_prio_ctrl_if;
  import irq_pkg::*;

  logic                 irq_req;
  logic [IRQ_VEC_W-1:0] irq_vec;
  logic [IPL_W-1:0]     irq_ipl;
  logic                 irq_ack;

  modport master (
    output irq_req,
    output irq_vec,
    output irq_ipl,
    input  irq_ack
  );

  modport slave (
    input  irq_req,
    input  irq_vec,
    input  irq_ipl,
    output irq_ack
  );

endinterface : irq_prio_ctrl_if

// File: rtl/irq_sync_edge.sv
// One interrupt line: multi-flop synchroniser, edge-detect delay flop and
// the pending register (level follows the line, edge latches until cleared).
module irq_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic EDGE        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic clr,
  output logic pending
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   sync;
  logic                   rise;

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~dly_q;

  // Synchronise the raw line, delay it one more cycle and update pending.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, exactly like hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      dly_q   <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      dly_q   <= sync;
      // A new edge in the same cycle as the clear keeps the line pending.
      pending <= EDGE ? (rise | (pending & ~clr)) : sync;
    end
  end

endmodule : irq_sync_edge

// File: rtl/irq_prio_ctrl.sv
// Fixed-priority interrupt controller: synchronises N_IRQ lines, picks the
// highest pending index and presents its vector until the CPU acknowledges.
module irq_prio_ctrl
  import irq_pkg::*;
#(
  parameter int                   N_IRQ       = 7,
  parameter logic [IRQ_VEC_W-1:0] VEC_BASE    = VEC_BASE_DEFAULT,
  parameter logic [N_IRQ-1:0]     EDGE_MASK   = 7'b0000010,
  parameter int                   SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_IRQ-1:0]     irq_in,
  irq_prio_ctrl_if.master      bus
);

  localparam int SEL_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  // Only seven autovector levels exist, and the synchroniser must be 2..3.
  if (N_IRQ < 1 || N_IRQ > 7) begin : g_bad_n_irq
    $error("irq_prio_ctrl: N_IRQ must be in 1..7");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("irq_prio_ctrl: SYNC_STAGES must be in 2..3");
  end

  logic [1:0]       rst_q;
  logic             rst_i;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] clr;
  logic             any_pending;
  logic [SEL_W-1:0] winner;
  logic [SEL_W-1:0] sel_q;
  irq_state_e       state_q;

  // Reset bridge: assert immediately with rst, release two clocks later.
  // NOTE: assertion is asynchronous so outputs drop at once; release is
  // synchronous so no flop sees reset removal near its clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_q <= 2'b11;
    else     rst_q <= {rst_q[0], 1'b0};
  end

  assign rst_i = rst_q[1];

  for (genvar i = 0; i < N_IRQ; i++) begin : g_line
    irq_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE        (EDGE_MASK[i])
    ) u_line (
      .clk     (clk),
      .rst     (rst_i),
      .din     (irq_in[i]),
      .clr     (clr[i]),
      .pending (pending[i])
    );
  end

  // Priority encoder: the highest pending index wins.
  // NOTE: every always_comb output gets a default before the loop so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    any_pending = |pending;
    winner      = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (pending[i]) winner = SEL_W'(i);
    end
  end

  // Acknowledge clears the delivered line; level lines ignore it.
  assign clr = (state_q == ST_REQ && bus.irq_ack) ? (N_IRQ'(1) << sel_q) : '0;

  // Handshake FSM with registered outputs; no preemption while in REQ.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      bus.irq_req <= 1'b0;
      bus.irq_vec <= '0;
      bus.irq_ipl <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_pending) begin
            sel_q       <= winner;
            bus.irq_req <= 1'b1;
            bus.irq_vec <= VEC_BASE + IRQ_VEC_W'(winner);
            bus.irq_ipl <= IPL_W'(winner) + IPL_W'(1);
            state_q     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.irq_ack) begin
            bus.irq_req <= 1'b0;
            bus.irq_ipl <= '0;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule : irq_prio_ctrl

// File: tb/tb_irq_prio_ctrl.sv
// Directed bench for irq_prio_ctrl: inputs change and outputs are sampled
// on the falling clock edge; expected values are hand-derived constants.
module tb_irq_prio_ctrl;
  import irq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] irq_in;
  int         n_vec = 0;
  int         n_err = 0;

  irq_prio_ctrl_if bus ();

  irq_prio_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .irq_in (irq_in),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic req, input logic [7:0] vec,
                           input logic [2:0] ipl);
    check({tag, ".req"}, 8'(bus.irq_req), 8'(req));
    check({tag, ".vec"}, bus.irq_vec, vec);
    check({tag, ".ipl"}, 8'(bus.irq_ipl), 8'(ipl));
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick(1);
      check({tag, ".req"}, 8'(bus.irq_req), 8'h00);
      check({tag, ".ipl"}, 8'(bus.irq_ipl), 8'h00);
    end
  endtask

  task automatic ack_pulse();
    bus.irq_ack = 1'b1;
    tick(1);
    bus.irq_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    irq_in      = '0;
    bus.irq_ack = 1'b0;
    tick(3);
    check_out("reset", 1'b0, 8'h00, 3'd0);
    rst = 1'b0;

    // Idle for 20 cycles after reset release.
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check_out("idle", 1'b0, 8'h00, 3'd0);
    end

    // Level line 0: request on the 4th edge after the rise.
    irq_in[IRQ_UART] = 1'b1;
    tick(3);
    check("lvl0.lat3.req", 8'(bus.irq_req), 8'h00);
    tick(1);
    check_out("lvl0.first", 1'b1, 8'h40, 3'd1);
    ack_pulse();
    check("lvl0.ack.req", 8'(bus.irq_req), 8'h00);
    check("lvl0.ack.ipl", 8'(bus.irq_ipl), 8'h00);
    tick(1);
    check("lvl0.hold.req", 8'(bus.irq_req), 8'h00);
    tick(1);
    check_out("lvl0.rereq", 1'b1, 8'h40, 3'd1);
    irq_in[IRQ_UART] = 1'b0;
    tick(5);
    check_out("lvl0.nowithdraw", 1'b1, 8'h40, 3'd1);
    ack_pulse();
    check_idle("lvl0.done", 10);

    // Edge line 1: 3-cycle pulse, one request, nothing after ack.
    irq_in[IRQ_SYSTICK] = 1'b1;
    tick(3);
    check("edge1.lat3.req", 8'(bus.irq_req), 8'h00);
    irq_in[IRQ_SYSTICK] = 1'b0;
    tick(1);
    check_out("edge1.first", 1'b1, 8'h41, 3'd2);
    tick(5);
    check_out("edge1.held", 1'b1, 8'h41, 3'd2);
    ack_pulse();
    check_idle("edge1.done", 10);

    // Two pulses on the edge line before ack coalesce into one request.
    irq_in[IRQ_SYSTICK] = 1'b1;
    tick(3);
    irq_in[IRQ_SYSTICK] = 1'b0;
    tick(1);
    check_out("edge2x.first", 1'b1, 8'h41, 3'd2);
    irq_in[IRQ_SYSTICK] = 1'b1;
    tick(2);
    irq_in[IRQ_SYSTICK] = 1'b0;
    tick(6);
    check_out("edge2x.held", 1'b1, 8'h41, 3'd2);
    ack_pulse();
    check_idle("edge2x.done", 10);

    // Lines 0 and 2 together: line 2 first, then line 0.
    irq_in[IRQ_UART] = 1'b1;
    irq_in[IRQ_ETH]  = 1'b1;
    tick(4);
    check_out("prio.first", 1'b1, 8'h42, 3'd3);
    irq_in[IRQ_ETH] = 1'b0;
    tick(5);
    ack_pulse();
    check("prio.ack.req", 8'(bus.irq_req), 8'h00);
    tick(2);
    check_out("prio.second", 1'b1, 8'h40, 3'd1);

    // Line 6 arrives while line 0 is presented: no preemption.
    irq_in[6] = 1'b1;
    tick(6);
    check_out("nopreempt.held", 1'b1, 8'h40, 3'd1);
    ack_pulse();
    tick(2);
    check_out("nopreempt.next", 1'b1, 8'h46, 3'd7);
    irq_in = '0;
    tick(5);
    ack_pulse();
    check_idle("nopreempt.done", 12);

    // Reset while an edge request is presented.
    irq_in[IRQ_SYSTICK] = 1'b1;
    tick(3);
    irq_in[IRQ_SYSTICK] = 1'b0;
    tick(1);
    check_out("rst.pre", 1'b1, 8'h41, 3'd2);
    rst = 1'b1;
    #1;
    check_out("rst.async", 1'b0, 8'h00, 3'd0);
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      check_out("rst.after", 1'b0, 8'h00, 3'd0);
    end

    // Ack while idle has no effect.
    ack_pulse();
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check_out("ack.idle", 1'b0, 8'h00, 3'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_irq_prio_ctrl
